processador_pio_poller: RTL and testbench
=========================================

PROCESSADOR_PIO_POLLER -- requirements
Module: processador_pio_poller

Interface
REQ-001 Parameters SHALL be:
- POLL_DIV, default 1000, clk cycles between poll reads.
- DEBOUNCE_N, default 4, consecutive disagreeing samples needed to change level.
- READ_LATENCY, default 1, slave readdata latency in cycles.
REQ-002 Ports SHALL be:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  polling enable.
- avm_address  out  2  Avalon-MM master address.
- avm_read  out  1  Avalon-MM read strobe.
- avm_readdata  in  32  slave read data; only bit 0 is used.
- level  out  1  debounced input level.
- rise  out  1  one-cycle pulse on a debounced 0->1 change.
- fall  out  1  one-cycle pulse on a debounced 1->0 change.
- sample_valid  out  1  one-cycle pulse when a raw sample is captured.
REQ-003 Design SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Parameter legality SHALL be: POLL_DIV >= READ_LATENCY+3, DEBOUNCE_N >= 1, READ_LATENCY >= 1; violation is a static elaboration error.

Function
REQ-005 Prescaler SHALL count 0..POLL_DIV-1 while enable=1, wrap to 0, and flag terminal count at value POLL_DIV-1.
REQ-006 FSM SHALL have states IDLE, REQ, WAIT, CAPTURE.
REQ-007 Transitions SHALL be:
- IDLE->REQ on terminal count with enable=1.
- REQ->WAIT after exactly 1 cycle.
- WAIT->CAPTURE after READ_LATENCY-1 further cycles; when READ_LATENCY=1, WAIT lasts 0 cycles and REQ goes directly to CAPTURE.
- CAPTURE->IDLE after 1 cycle.
REQ-008 avm_read SHALL be 1 only in REQ (exactly one cycle per poll), and avm_address SHALL be constant 0.
REQ-009 Raw sample = avm_readdata[0], registered at the clock edge ending the cycle READ_LATENCY cycles after the REQ cycle; sample_valid SHALL pulse in the cycle after that edge.
REQ-010 Debounce SHALL work as follows:
- A sample equal to level clears the disagree counter.
- A sample differing from level increments the counter.
- When the counter reaches DEBOUNCE_N, level toggles and the counter clears.
REQ-011 rise or fall SHALL assert for exactly one cycle, coincident with the first cycle level shows its new value; rise and fall SHALL never be simultaneously 1.
REQ-012 enable deasserted mid-transaction: the in-flight read SHALL complete and be processed; afterwards FSM stays IDLE and the prescaler holds at 0.
REQ-013 enable re-asserted: the first poll SHALL occur POLL_DIV cycles later; debounce state and level are retained.
REQ-014 Terminal count while FSM is not IDLE SHALL be impossible by REQ-004 and need not be handled.
REQ-015 Disagree counter width SHALL be clog2(DEBOUNCE_N+1) and SHALL saturate, never wrap.

Reset
REQ-016 On reset_n=0, asynchronously: FSM=IDLE, prescaler=0, disagree counter=0, level=0, rise=fall=sample_valid=avm_read=0, avm_address=0.
REQ-017 Reset mid-transaction SHALL abandon the read with no sample processed; the first post-reset poll SHALL occur POLL_DIV cycles after reset release with enable=1.

Structure
REQ-018 Package processador_pio_pkg SHALL hold the FSM state enum and constant PIO_DATA_ADDR=2'd0.
REQ-019 Debounce (REQ-010, REQ-011, REQ-015) SHALL be sub-module processador_pio_debounce, taking sample and sample_valid and producing level, rise and fall.

Verification (POLL_DIV=8, DEBOUNCE_N=3, READ_LATENCY=1, slave model registers in_port every clk)
REQ-020 Reset release, enable=1 -> avm_read high in cycles 8, 16, 24; each pulse is 1 cycle wide; avm_address=0 throughout.
REQ-021 in_port held 1 from reset -> level=1 and a single rise pulse after the 3rd poll; no fall pulses.
REQ-022 in_port toggles 1,1,0,1,1,1 across successive polls -> the 0 clears the counter; rise occurs only after the last three 1 samples.
REQ-023 enable dropped the cycle after avm_read -> sample_valid still pulses once; no further avm_read; re-enable -> next avm_read 8 cycles later.
REQ-024 reset_n asserted in the REQ cycle -> all outputs 0 immediately; no sample_valid; after release, the first poll occurs at cycle 8.
REQ-025 in_port 1->0 after level=1 -> fall pulses exactly once after 3 polls of 0; rise stays 0.

Source files
------------

// File: rtl/processador_pio_pkg.sv
// rtl/processador_pio_pkg.sv - shared types and constants for the PIO poller
package processador_pio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } pio_state_e;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/processador_pio_debounce.sv
// rtl/processador_pio_debounce.sv - N-consecutive-sample debouncer with edge pulses
module processador_pio_debounce #(
    parameter int DEBOUNCE_N = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample,
    input  logic sample_valid,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_N + 1);
    localparam logic [CW-1:0] N_VAL = CW'(DEBOUNCE_N);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    // Saturating increment so the counter can never wrap back to a small value.
    assign cnt_inc = (cnt == N_VAL) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sample_valid) begin
                if (sample == level) begin
                    cnt <= '0;
                end else if (cnt_inc == N_VAL) begin
                    level <= ~level;
                    rise  <= ~level;
                    fall  <= level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: rtl/processador_pio_poller.sv
// rtl/processador_pio_poller.sv - periodic Avalon-MM poll of a PIO bit with debounce
module processador_pio_poller
    import processador_pio_pkg::*;
#(
    parameter int POLL_DIV     = 1000,
    parameter int DEBOUNCE_N   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        level,
    output logic        rise,
    output logic        fall,
    output logic        sample_valid
);

    if (POLL_DIV < READ_LATENCY + 3 || DEBOUNCE_N < 1 || READ_LATENCY < 1) begin : g_bad_params
        $error("processador_pio_poller: illegal POLL_DIV/DEBOUNCE_N/READ_LATENCY");
    end

    localparam int PW = $clog2(POLL_DIV);
    localparam int WW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(POLL_DIV - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    pio_state_e    state;
    logic [PW-1:0] prescaler;
    logic [WW-1:0] wait_cnt;
    logic          sample;
    logic          tc;
    logic          unused_readdata;

    assign avm_address     = PIO_DATA_ADDR;
    assign tc              = enable && (prescaler == PRE_LAST);
    assign unused_readdata = ^avm_readdata[31:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            prescaler    <= '0;
            wait_cnt     <= '0;
            avm_read     <= 1'b0;
            sample       <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            // Dropping enable parks the prescaler at 0 so re-enable restarts a full period.
            if (!enable || prescaler == PRE_LAST) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PW'(1);
            end

            avm_read     <= 1'b0;
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tc) begin
                        state    <= REQ;
                        avm_read <= 1'b1;
                    end
                end
                REQ: begin
                    wait_cnt <= '0;
                    state    <= (READ_LATENCY == 1) ? CAPTURE : WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                CAPTURE: begin
                    sample       <= avm_readdata[0];
                    sample_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    processador_pio_debounce #(
        .DEBOUNCE_N(DEBOUNCE_N)
    ) u_debounce (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample      (sample),
        .sample_valid(sample_valid),
        .level       (level),
        .rise        (rise),
        .fall        (fall)
    );

endmodule

// File: tb/tb_processador_pio_poller.sv
// tb/tb_processador_pio_poller.sv - self-checking bench for processador_pio_poller
module tb_processador_pio_poller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        level;
    logic        rise;
    logic        fall;
    logic        sample_valid;
    logic        in_port;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    int read_q[$];
    int rise_q[$];
    int fall_q[$];
    int sv_q[$];

    processador_pio_poller #(
        .POLL_DIV    (8),
        .DEBOUNCE_N  (3),
        .READ_LATENCY(1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .avm_address (avm_address),
        .avm_read    (avm_read),
        .avm_readdata(avm_readdata),
        .level       (level),
        .rise        (rise),
        .fall        (fall),
        .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        avm_readdata <= {31'd0, in_port};
    end

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Behavioural model: polls fall every 8 enabled cycles from the start of an
    // enabled run; each poll yields a sample two cycles later; 3 disagreeing
    // samples in a row flip the level one cycle after the sample.
    bit m_run      = 1'b0;
    int m_start    = 0;
    int m_next_rd  = -1;
    int m_sv_at    = -1;
    bit m_sample   = 1'b0;
    bit m_lvl      = 1'b0;
    bit m_lvl_out  = 1'b0;
    int m_cnt      = 0;
    int m_pulse_at = -1;

    always @(negedge clk) begin
        bit e_read, e_sv, e_rise, e_fall;
        if (avm_read)     read_q.push_back(cyc);
        if (rise)         rise_q.push_back(cyc);
        if (fall)         fall_q.push_back(cyc);
        if (sample_valid) sv_q.push_back(cyc);
        chk("avm_address", int'(avm_address), 0);
        if (!reset_n) begin
            chk("rst_avm_read", int'(avm_read), 0);
            chk("rst_sample_valid", int'(sample_valid), 0);
            chk("rst_level", int'(level), 0);
            chk("rst_rise", int'(rise), 0);
            chk("rst_fall", int'(fall), 0);
            m_run = 1'b0; m_next_rd = -1; m_sv_at = -1; m_lvl = 1'b0;
            m_lvl_out = 1'b0; m_cnt = 0; m_pulse_at = -1;
        end else begin
            if (cyc == m_pulse_at) m_lvl_out = m_lvl;
            e_read = (cyc == m_next_rd);
            e_sv   = (cyc == m_sv_at);
            e_rise = (cyc == m_pulse_at) && m_lvl;
            e_fall = (cyc == m_pulse_at) && !m_lvl;
            chk("avm_read", int'(avm_read), int'(e_read));
            chk("sample_valid", int'(sample_valid), int'(e_sv));
            chk("level", int'(level), int'(m_lvl_out));
            chk("rise", int'(rise), int'(e_rise));
            chk("fall", int'(fall), int'(e_fall));
            if (e_read) begin
                m_sample = in_port;
                m_sv_at  = cyc + 2;
            end
            if (e_sv) begin
                if (m_sample == m_lvl) m_cnt = 0;
                else begin
                    m_cnt++;
                    if (m_cnt == 3) begin
                        m_lvl = !m_lvl; m_cnt = 0; m_pulse_at = cyc + 1;
                    end
                end
            end
            if (enable) begin
                if (!m_run) begin m_run = 1'b1; m_start = cyc; end
                if ((cyc - m_start) % 8 == 7) m_next_rd = cyc + 1;
            end else begin
                m_run = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic poll_with(input logic v, output int rc);
        rc = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (avm_read) begin rc = cyc; break; end
        end
        if (rc < 0) chk("poll_timeout", 0, 1);
        else in_port = v;
    endtask

    task automatic clear_q();
        read_q.delete(); rise_q.delete(); fall_q.delete(); sv_q.delete();
    endtask

    initial begin
        int rel, rel2, rc, e;
        reset_n = 1'b0; enable = 1'b0; in_port = 1'b0;
        step(3);

        // Reset release with input held high: polls at 8/16/24, rise at 27.
        in_port = 1'b1; enable = 1'b1; reset_n = 1'b1; rel = cyc;
        clear_q();
        step(30);
        chk("p1_read_count", read_q.size(), 3);
        if (read_q.size() >= 3) begin
            chk("p1_read0", read_q[0] - rel, 8);
            chk("p1_read1", read_q[1] - rel, 16);
            chk("p1_read2", read_q[2] - rel, 24);
        end
        chk("p1_rise_count", rise_q.size(), 1);
        if (rise_q.size() == 1) chk("p1_rise_cycle", rise_q[0] - rel, 27);
        chk("p1_fall_count", fall_q.size(), 0);
        chk("p1_level", int'(level), 1);

        // Input drops to 0: polls at 32/40/48 give fall at 51.
        in_port = 1'b0;
        clear_q();
        step(25);
        chk("p2_fall_count", fall_q.size(), 1);
        if (fall_q.size() == 1) chk("p2_fall_cycle", fall_q[0] - rel, 51);
        chk("p2_rise_count", rise_q.size(), 0);
        chk("p2_level", int'(level), 0);

        // Samples 1,1,0,1,1,1: the 0 clears the count, rise after the sixth.
        clear_q();
        poll_with(1'b1, rc); poll_with(1'b1, rc); poll_with(1'b0, rc);
        poll_with(1'b1, rc); poll_with(1'b1, rc); poll_with(1'b1, rc);
        step(5);
        chk("p3_last_poll", rc - rel, 96);
        chk("p3_rise_count", rise_q.size(), 1);
        if (rise_q.size() == 1) chk("p3_rise_cycle", rise_q[0] - rel, 99);
        chk("p3_fall_count", fall_q.size(), 0);

        // Enable dropped right after the read: sample still lands, polling stops.
        poll_with(1'b1, rc);
        step(1);
        enable = 1'b0;
        clear_q();
        step(20);
        chk("p4_sv_count", sv_q.size(), 1);
        if (sv_q.size() == 1) chk("p4_sv_cycle", sv_q[0] - rc, 2);
        chk("p4_idle_reads", read_q.size(), 0);
        enable = 1'b1; e = cyc;
        clear_q();
        step(10);
        chk("p4_reen_reads", read_q.size(), 1);
        if (read_q.size() == 1) chk("p4_reen_delay", read_q[0] - e, 8);
        chk("p4_level_kept", int'(level), 1);

        // Reset during the REQ cycle: outputs clear at once, read abandoned.
        poll_with(1'b1, rc);
        reset_n = 1'b0;
        #1;
        chk("p5_read_now", int'(avm_read), 0);
        chk("p5_sv_now", int'(sample_valid), 0);
        chk("p5_level_now", int'(level), 0);
        chk("p5_rise_now", int'(rise), 0);
        chk("p5_fall_now", int'(fall), 0);
        clear_q();
        step(2);
        reset_n = 1'b1; rel2 = cyc;
        step(9);
        chk("p5_sv_count", sv_q.size(), 0);
        chk("p5_read_count", read_q.size(), 1);
        if (read_q.size() == 1) chk("p5_first_poll", read_q[0] - rel2, 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
